// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, one-outstanding imem handshake, IF/ID register with skid buffer.
// Optional IFETCH_STATS_EN adds fetchCount/stallCount statistics outputs.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic [31:0] Instruction,
    output logic        instrValid,
    output logic [31:0] instrPc,
    output logic [31:0] pcPlus4
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] stallCount
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_FULL,
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instrPc;
    logic [31:0] r_pcPlus4;
    logic        r_valid;
    logic [31:0] r_skidData;
    logic [31:0] r_skidPc;
    logic        r_skidValid;

    logic [31:0] w_rspPc;
    logic        w_free;
    logic        w_consumed;
    logic        w_loadRsp;
    logic        w_loadSkid;

    // pc only advances on grant, so the word in flight always belongs to pc-4
    assign w_rspPc    = r_pc - 32'd4;
    assign w_free     = ~r_valid | ~stall;
    assign w_consumed = r_valid & ~stall;
    assign w_loadRsp  = ~redirect & (r_state == S_WAIT) & imemRvalid & w_free;
    assign w_loadSkid = ~redirect & (r_state == S_FULL) & ~stall & r_skidValid;

    assign imemReq     = (r_state == S_REQ);
    assign imemAddr    = r_pc;
    assign Instruction = r_instr;
    assign instrValid  = r_valid;
    assign instrPc     = r_instrPc;
    assign pcPlus4     = r_pcPlus4;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_instrPc   <= '0;
            r_pcPlus4   <= '0;
            r_valid     <= 1'b0;
            r_skidData  <= '0;
            r_skidPc    <= '0;
            r_skidValid <= 1'b0;
        end else if (redirect) begin
            r_pc        <= redirectPc & ~32'd3;
            r_valid     <= 1'b0;
            r_instr     <= '0;
            r_skidValid <= 1'b0;
            case (r_state)
                S_REQ:   r_state <= imemGnt ? S_DRAIN : S_REQ;
                S_WAIT:  r_state <= imemRvalid ? S_REQ : S_DRAIN;
                S_FULL:  r_state <= S_REQ;
                S_DRAIN: r_state <= imemRvalid ? S_REQ : S_DRAIN;
                default: r_state <= S_REQ;
            endcase
        end else begin
            // consumption clears the output; a load later in this block overrides it
            if (w_consumed) begin
                r_valid <= 1'b0;
                r_instr <= '0;
            end
            case (r_state)
                S_REQ: begin
                    if (imemGnt) begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imemRvalid) begin
                        if (w_loadRsp) begin
                            r_instr   <= imemRdata;
                            r_valid   <= 1'b1;
                            r_instrPc <= w_rspPc;
                            r_pcPlus4 <= r_pc;
                        end else begin
                            r_skidData  <= imemRdata;
                            r_skidPc    <= w_rspPc;
                            r_skidValid <= 1'b1;
                        end
                        r_state <= w_loadRsp ? S_REQ : S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_loadSkid) begin
                        r_instr     <= r_skidData;
                        r_valid     <= 1'b1;
                        r_instrPc   <= r_skidPc;
                        r_pcPlus4   <= r_skidPc + 32'd4;
                        r_skidValid <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imemRvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

`ifdef IFETCH_STATS_EN
    logic [31:0] r_fetchCount;
    logic [31:0] r_stallCount;

    assign fetchCount = r_fetchCount;
    assign stallCount = r_stallCount;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetchCount <= '0;
            r_stallCount <= '0;
        end else begin
            if (w_loadRsp || w_loadSkid) begin
                r_fetchCount <= r_fetchCount + 32'd1;
            end
            if (r_valid && stall) begin
                r_stallCount <= r_stallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Upstream neighbour of the decode stage: holds the program counter and issues word fetches to instruction memory over a request/grant/response handshake.
- Registers each returned word into the IF/ID output, which drives the decode stage's 32-bit `Instruction` input directly.
- Supports a decode-side stall (output held), a branch/jump redirect (flush), and a one-entry skid buffer so a response is never lost while stalled.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imemReq  out  1  fetch request valid.
- imemAddr  out  32  word-aligned fetch address; equals pc while imemReq=1.
- imemGnt  in  1  memory accepts the request this cycle.
- imemRvalid  in  1  response valid; arrives in order, ≥1 cycle after grant.
- imemRdata  in  32  response word.
- stall  in  1  decode/hazard hold: output register must not change.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirectPc  in  32  redirect target; bits [1:0] ignored, forced to 0.
- Instruction  out  32  IF/ID instruction word to decode.
- instrValid  out  1  Instruction holds a live instruction.
- instrPc  out  32  address of Instruction.
- pcPlus4  out  32  instrPc + 4, registered with Instruction.

## Operation
- At most one outstanding memory request.
- FSM states: REQ, WAIT, FULL, DRAIN.
- **REQ:** imemReq=1. On imemGnt: pc <= pc+4, go WAIT.
- **WAIT:** imemReq=0. On imemRvalid:
  - If output is free (instrValid=0 or stall=0): load output {Instruction=imemRdata, instrValid=1, instrPc, pcPlus4}, go REQ.
  - Otherwise: capture word and its PC into the skid buffer, go FULL.
- **FULL:** imemReq=0. When stall=0: move skid into output, go REQ.
- **DRAIN:** imemReq=0. Wait for the stale response; on imemRvalid discard it, go REQ.
- Consumption: output is consumed on any cycle with instrValid=1 and stall=0. If consumed and nothing new loads: instrValid <= 0, Instruction <= 32'h0 (NOP).
- Redirect has highest priority and overrides stall:
  - pc <= {redirectPc[31:2],2'b00}.
  - instrValid <= 0, Instruction <= 0, skid cleared.
  - Next state by current state: REQ → REQ, or DRAIN if imemGnt was high the same cycle. WAIT → DRAIN, or REQ if imemRvalid was high the same cycle (response dropped). FULL → REQ. DRAIN → DRAIN, or REQ if imemRvalid the same cycle.
- Arithmetic: pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Address width is a fixed 32 bits.

## Timing
- Reset values:
  - state=REQ, pc=RESET_PC.
  - imemReq=1 from the first cycle after reset deasserts (combinational from state).
  - imemAddr=RESET_PC.
  - Instruction=0, instrValid=0, instrPc=0, pcPlus4=0, skid empty.
- Reset mid-operation: returns to the reset state immediately. Any in-flight response arriving after reset deasserts is treated as a normal WAIT response only if issued after reset; memory is required to cancel on reset.
- Latency: grant in cycle N → rvalid earliest N+1 → Instruction valid in N+2.
- Throughput: with 1-cycle memory and no stall, one instruction per 2 cycles.
- imemReq, imemAddr are Moore outputs; all IF/ID outputs are registered.
- imemRvalid outside WAIT/DRAIN is a protocol error and is ignored.

## Configuration
- `IFETCH_STATS_EN` defined adds two outputs, both reset to 0 and wrapping at 2^32:
  - fetchCount (out, 32): +1 per word loaded into the output register.
  - stallCount (out, 32): +1 per cycle with instrValid=1 and stall=1.
- Undefined: both ports and their counters are absent; behaviour is otherwise identical.

## Test plan
- **Reset fetch:** reset, then 1-cycle memory with constant grant returning addr-tagged words → imemAddr sequence 0,4,8; Instruction 0x00000000-tag, instrPc 0,4,8 on every second cycle; pcPlus4 = instrPc+4.
- **Stall with skid:** stall=1 while instruction @4 is held and the @8 response arrives → Instruction stays @4, no imemReq; stall=0 → @8 appears next cycle, then request to 12.
- **Redirect in WAIT:** redirect to 0x100 while WAIT → instrValid=0, Instruction=0, the stale response is dropped, next request addr 0x100.
- **Simultaneous events:** redirect with redirectPc=0x103 in the same cycle as rvalid, with stall=1 → response dropped, next addr 0x100, state REQ.
- **Wrap and stats:** RESET_PC=32'hFFFF_FFFC, 2 fetches → addresses FFFF_FFFC then 0. With `IFETCH_STATS_EN`, 3 loads + 4 stall cycles → fetchCount=3, stallCount=4.
